lcd_scanout: RTL and testbench
==============================

Name: lcd_scanout

Overview:
- Parametrised video scan-out engine that generates 640x480 timing on clock25 and reads a Game Boy-resolution pixel-ID frame store.
- Each source pixel is replicated SCALE x SCALE and centred in the active area.
- Pixel IDs (palette select plus 2-bit shade) map through a writable RGB555 palette RAM, with a programmable border colour and an LCD-off blanking mode.
- Sits between the frame store written by the PPU and the HDMI transmitter pins.

Parameters:
SRC_W, 160, source pixels per line
SRC_H, 144, source lines per frame
SCALE, 3, integer replication factor in both axes (SRC_W*SCALE <= H_ACTIVE, SRC_H*SCALE <= V_ACTIVE)
H_ACTIVE, 640, visible clocks per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, sync active level (0 = active-low)
PAL_BITS, 2, palette-select bits; there are 2^PAL_BITS palettes of 4 entries each
ADDR_W, 15, frame-store address width

Ports:
clock25  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
fb_addr  out  ADDR_W  frame-store read address, sy*SRC_W+sx
fb_data  in  PAL_BITS+2  pixel ID returned exactly 1 clock after fb_addr
lcd_on  in  1  0: window shows white 0x7fff instead of frame data
pal_we  in  1  palette write strobe
pal_addr  in  PAL_BITS+2  palette entry index
pal_wdata  in  15  RGB555 colour, bits [4:0]=R, [9:5]=G, [14:10]=B
border_we  in  1  border colour write strobe
border_wdata  in  15  RGB555 border colour
r, g, b  out  8 each  registered colour
de  out  1  data enable
hs, vs  out  1 each  syncs, polarity per SYNC_POL
frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame

Behaviour:
- Reset: hc=vc=0; r/g/b=0; de=0; hs=vs=inactive (~SYNC_POL); frame_start=0; fb_addr=0; border=0.
- Reset palette: every palette holds 0x67fd, 0x4b55, 0x3a2a, 0x1ca2 for shades 0..3.
- Reset mid-frame aborts the frame immediately; timing restarts at hc=vc=0 on release.

Counters:
- hc runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- vc increments when hc wraps and runs 0..V_TOTAL-1.
- Active region: hc < H_ACTIVE and vc < V_ACTIVE.
- hs is active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vs is active for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).

Window:
- X_OFF = (H_ACTIVE-SRC_W*SCALE)/2 and Y_OFF = (V_ACTIVE-SRC_H*SCALE)/2; defaults are 80 and 24.
- A pixel is in the window when X_OFF <= hc < X_OFF+SRC_W*SCALE and Y_OFF <= vc < Y_OFF+SRC_H*SCALE.

Source coordinates (no dividers):
- sx/xphase counters:
  - Reset to 0 at hc == X_OFF.
  - xphase counts 0..SCALE-1; sx increments when xphase wraps.
- sy/yphase counters:
  - Reset at vc == Y_OFF on the line wrap.
  - yphase advances once per line; sy increments when yphase wraps.
- Outside the window the counters hold. sx never exceeds SRC_W-1 and sy never exceeds SRC_H-1.

Pipeline (fixed 3-clock latency from counter state to output pins):
- S0 counters → S1 fb_addr registered.
- S1 → S2 fb_data valid.
- S2 → S3 palette lookup and output register.
- de, hs, vs, window and frame_start are delayed through matching 3-stage shift registers.

Colour select at S3:
- de=0: r/g/b = 0.
- de=1 and outside the window: border colour.
- Inside the window with lcd_on=0: 0x7fff.
- Otherwise: palette[fb_data].
- lcd_on is sampled at S2.

RGB555 to 8 bit: each channel maps to {c5, c5[4:2]}, so 0x1f becomes 0xff and 0 becomes 0.

Palette and border writes:
- Take effect on the clock edge.
- A lookup in the same cycle as a write to the same entry returns the old value; the new value is visible from the next pixel on.
- Both write ports accept writes at any time, including during active video.

frame_start:
- Asserted when the S3 output corresponds to hc=0, vc=0.

Test Plan:
- Reset release → after 3 clocks de rises at hc=0,vc=0 with frame_start=1; hs low for clocks 656..751 of each line; vs low on lines 490..491; frame period 800*525 = 420000 clocks.
- Frame store returns ID = sx[1:0], default palette → output line 24, pixels 80..82 are {0x67,0xfd→...} per mapping of 0x67fd (r=0xef, g=0xff, b=0xce); pixel 83 switches to the 0x4b55 colour; fb_addr increments every 3 clocks.
- Address sequence → fb_addr=0 at first window pixel; lines 24..26 all reread 0..159; line 27 starts at 160; last window line 455 ends at 23039.
- border_we with 0x001f → pixels hc 0..79 and 560..639 show r=0xff, g=0, b=0; window content unchanged.
- pal_we at addr 5 = 0x7c00, fb_data=5 → b=0xff, r=g=0; write coinciding with a lookup of entry 5 shows the old value for that pixel only.
- lcd_on=0 → window pixels r=g=b=0xff, border still shown; assert resetn low mid-line → outputs zero, syncs inactive asynchronously, timing restarts at hc=0.

Source files
------------

// File: rtl/lcd_scanout_if.sv
// Bus between the scan-out engine and its surroundings: frame-store read port,
// palette/border write ports, LCD enable and the registered video outputs.
interface lcd_scanout_if #(
  parameter int PAL_BITS = 2,
  parameter int ADDR_W   = 15
);
  logic [ADDR_W-1:0]   fb_addr;
  logic [PAL_BITS+1:0] fb_data;
  logic                lcd_on;
  logic                pal_we;
  logic [PAL_BITS+1:0] pal_addr;
  logic [14:0]         pal_wdata;
  logic                border_we;
  logic [14:0]         border_wdata;
  logic [7:0]          r;
  logic [7:0]          g;
  logic [7:0]          b;
  logic                de;
  logic                hs;
  logic                vs;
  logic                frame_start;

  modport master (
    output fb_addr, r, g, b, de, hs, vs, frame_start,
    input  fb_data, lcd_on, pal_we, pal_addr, pal_wdata, border_we, border_wdata
  );

  modport slave (
    input  fb_addr, r, g, b, de, hs, vs, frame_start,
    output fb_data, lcd_on, pal_we, pal_addr, pal_wdata, border_we, border_wdata
  );
endinterface

// File: rtl/lcd_scanout.sv
// Video timing generator that scales and centres a pixel-ID frame store,
// maps IDs through an RGB555 palette and drives RGB888 plus syncs.
module lcd_scanout #(
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 144,
  parameter int SCALE    = 3,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PAL_BITS = 2,
  parameter int ADDR_W   = 15
) (
  input  logic          clock25,
  input  logic          resetn,
  lcd_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SXW     = $clog2(SRC_W + 1);
  localparam int SYW     = $clog2(SRC_H + 1);
  localparam int PW      = $clog2(SCALE + 1);
  localparam int NPAL    = 1 << (PAL_BITS + 2);
  localparam int X_OFF   = (H_ACTIVE - SRC_W * SCALE) / 2;
  localparam int Y_OFF   = (V_ACTIVE - SRC_H * SCALE) / 2;

  localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]  X_BEG   = HW'(X_OFF);
  localparam logic [HW-1:0]  X_END   = HW'(X_OFF + SRC_W * SCALE);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]  Y_BEG   = VW'(Y_OFF);
  localparam logic [VW-1:0]  Y_END   = VW'(Y_OFF + SRC_H * SCALE);
  localparam logic [SXW-1:0] SX_LAST = SXW'(SRC_W - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SRC_H - 1);
  localparam logic [PW-1:0]  PH_LAST = PW'(SCALE - 1);

  function automatic logic [14:0] def_colour(input logic [1:0] shade);
    case (shade)
      2'd0:    return 15'h67fd;
      2'd1:    return 15'h4b55;
      2'd2:    return 15'h3a2a;
      default: return 15'h1ca2;
    endcase
  endfunction

  logic [HW-1:0]     hc_q, hc_d;
  logic [VW-1:0]     vc_q, vc_d;
  logic [SXW-1:0]    sx_q, sx_d;
  logic [SYW-1:0]    sy_q, sy_d;
  logic [PW-1:0]     xph_q, xph_d;
  logic [PW-1:0]     yph_q, yph_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]        de_sr_q, de_sr_d;
  logic [2:0]        hs_sr_q, hs_sr_d;
  logic [2:0]        vs_sr_q, vs_sr_d;
  logic [2:0]        fs_sr_q, fs_sr_d;
  logic [1:0]        win_sr_q, win_sr_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [14:0]       border_q, border_d;
  logic [14:0]       pal_q [NPAL];
  logic [14:0]       pal_d [NPAL];
  logic              win, act, hs_on, vs_on;
  logic [14:0]       col;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end

    win   = (hc_q >= X_BEG) && (hc_q < X_END) && (vc_q >= Y_BEG) && (vc_q < Y_END);
    act   = (hc_q < H_ACT) && (vc_q < V_ACT);
    hs_on = (hc_q >= HS_BEG) && (hc_q < HS_END);
    vs_on = (vc_q >= VS_BEG) && (vc_q < VS_END);

    // Source x restarts at the window's left edge; clamps so it never runs past the last column.
    sx_d  = sx_q;
    xph_d = xph_q;
    if (hc_d == X_BEG) begin
      sx_d  = '0;
      xph_d = '0;
    end else if (win) begin
      if (xph_q == PH_LAST) begin
        xph_d = '0;
        if (sx_q != SX_LAST) sx_d = sx_q + 1'b1;
      end else begin
        xph_d = xph_q + 1'b1;
      end
    end

    sy_d  = sy_q;
    yph_d = yph_q;
    if (hc_q == H_LAST) begin
      if (vc_d == Y_BEG) begin
        sy_d  = '0;
        yph_d = '0;
      end else if ((vc_q >= Y_BEG) && (vc_q < Y_END)) begin
        if (yph_q == PH_LAST) begin
          yph_d = '0;
          if (sy_q != SY_LAST) sy_d = sy_q + 1'b1;
        end else begin
          yph_d = yph_q + 1'b1;
        end
      end
    end

    fb_addr_d = ADDR_W'(sy_q) * ADDR_W'(SRC_W) + ADDR_W'(sx_q);

    de_sr_d  = {de_sr_q[1:0], act};
    hs_sr_d  = {hs_sr_q[1:0], hs_on ? SYNC_POL : ~SYNC_POL};
    vs_sr_d  = {vs_sr_q[1:0], vs_on ? SYNC_POL : ~SYNC_POL};
    fs_sr_d  = {fs_sr_q[1:0], (hc_q == '0) && (vc_q == '0)};
    win_sr_d = {win_sr_q[0], win};

    // Palette and border are read before this edge's writes land, so a
    // same-cycle write shows up from the next pixel.
    col = 15'h0000;
    if (de_sr_q[1]) begin
      if (!win_sr_q[1])     col = border_q;
      else if (!bus.lcd_on) col = 15'h7fff;
      else                  col = pal_q[bus.fb_data];
    end
    rgb_d = {col[4:0], col[4:2], col[9:5], col[9:7], col[14:10], col[14:12]};

    border_d = bus.border_we ? bus.border_wdata : border_q;
    pal_d    = pal_q;
    if (bus.pal_we) pal_d[bus.pal_addr] = bus.pal_wdata;
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      hc_q      <= '0;
      vc_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      xph_q     <= '0;
      yph_q     <= '0;
      fb_addr_q <= '0;
      de_sr_q   <= '0;
      hs_sr_q   <= {3{~SYNC_POL}};
      vs_sr_q   <= {3{~SYNC_POL}};
      fs_sr_q   <= '0;
      win_sr_q  <= '0;
      rgb_q     <= '0;
      border_q  <= '0;
      for (int i = 0; i < NPAL; i++) pal_q[i] <= def_colour(2'(i));
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      xph_q     <= xph_d;
      yph_q     <= yph_d;
      fb_addr_q <= fb_addr_d;
      de_sr_q   <= de_sr_d;
      hs_sr_q   <= hs_sr_d;
      vs_sr_q   <= vs_sr_d;
      fs_sr_q   <= fs_sr_d;
      win_sr_q  <= win_sr_d;
      rgb_q     <= rgb_d;
      border_q  <= border_d;
      pal_q     <= pal_d;
    end
  end

  assign bus.fb_addr     = fb_addr_q;
  assign bus.r           = rgb_q[23:16];
  assign bus.g           = rgb_q[15:8];
  assign bus.b           = rgb_q[7:0];
  assign bus.de          = de_sr_q[2];
  assign bus.hs          = hs_sr_q[2];
  assign bus.vs          = vs_sr_q[2];
  assign bus.frame_start = fs_sr_q[2];
endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: full 800-clock line timing with a short frame
// (4 source lines, 20 visible lines, 27 total) so whole frames fit in a short run.
module tb_lcd_scanout;
  localparam int HT    = 800;
  localparam int VT    = 27;
  localparam int FRAME = HT * VT;

  logic clock25 = 1'b0;
  logic resetn  = 1'b0;
  always #20 clock25 = ~clock25;

  lcd_scanout_if #(.PAL_BITS(2), .ADDR_W(15)) bus ();

  lcd_scanout #(
    .SRC_W(160), .SRC_H(4), .SCALE(3),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .PAL_BITS(2), .ADDR_W(15)
  ) dut (
    .clock25(clock25),
    .resetn (resetn),
    .bus    (bus)
  );

  // Frame store: one-clock read latency; mode 0 returns addr[1:0] (= sx[1:0]
  // since 160 is a multiple of 4), mode 1 returns ID 5 everywhere.
  int fs_mode = 0;
  always @(posedge clock25)
    bus.fb_data <= (fs_mode == 0) ? {2'b00, bus.fb_addr[1:0]} : 4'd5;

  int checks  = 0;
  int errors  = 0;
  int n_edges = 0;

  typedef struct {
    int          f;
    int          vc;
    int          hc;
    logic [23:0] rgb;
    logic [3:0]  ctl;   // {de, hs, vs, frame_start}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int f, input int vc, input int hc,
                              input logic [23:0] rgb, input logic [3:0] ctl);
    vec_t v;
    v.f = f; v.vc = vc; v.hc = hc; v.rgb = rgb; v.ctl = ctl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock25);
    n_edges++;
    #1;
  endtask

  task automatic goto_edge(input string name, input int target);
    if (target < n_edges) begin
      checks++;
      errors++;
      $display("FAIL %s: sequence already at edge %0d, needed %0d", name, n_edges, target);
    end
    while (n_edges < target) tick();
  endtask

  // Output pins show pixel P three edges after release; fb_addr shows it one edge after.
  task automatic goto_px(input int f, input int vc, input int hc);
    goto_edge($sformatf("goto px f%0d v%0d h%0d", f, vc, hc), f * FRAME + vc * HT + hc + 3);
  endtask

  task automatic goto_addr(input int f, input int vc, input int hc);
    goto_edge($sformatf("goto addr f%0d v%0d h%0d", f, vc, hc), f * FRAME + vc * HT + hc + 1);
  endtask

  task automatic chk_rgb(input string name, input logic [23:0] exp);
    chk(name, {8'h00, bus.r, bus.g, bus.b}, {8'h00, exp});
  endtask

  task automatic chk_ctl(input string name, input logic [3:0] exp);
    chk(name, {28'h0, bus.de, bus.hs, bus.vs, bus.frame_start}, {28'h0, exp});
  endtask

  initial begin
    bus.lcd_on       = 1'b1;
    bus.pal_we       = 1'b0;
    bus.pal_addr     = '0;
    bus.pal_wdata    = '0;
    bus.border_we    = 1'b0;
    bus.border_wdata = '0;

    // Window: x 80..559, y 4..15; hsync 656..751; vsync lines 22..23.
    vecs.push_back(mk(0,  0,   0, 24'h000000, 4'b1111));
    vecs.push_back(mk(0,  0,   1, 24'h000000, 4'b1110));
    vecs.push_back(mk(0,  0, 639, 24'h000000, 4'b1110));
    vecs.push_back(mk(0,  0, 640, 24'h000000, 4'b0110));
    vecs.push_back(mk(0,  0, 655, 24'h000000, 4'b0110));
    vecs.push_back(mk(0,  0, 656, 24'h000000, 4'b0010));
    vecs.push_back(mk(0,  0, 751, 24'h000000, 4'b0010));
    vecs.push_back(mk(0,  0, 752, 24'h000000, 4'b0110));
    vecs.push_back(mk(0,  3, 100, 24'h000000, 4'b1110));
    vecs.push_back(mk(0,  4,  79, 24'h000000, 4'b1110));
    vecs.push_back(mk(0,  4,  80, 24'hefffce, 4'b1110));
    vecs.push_back(mk(0,  4,  82, 24'hefffce, 4'b1110));
    vecs.push_back(mk(0,  4,  83, 24'hadd694, 4'b1110));
    vecs.push_back(mk(0,  4,  86, 24'h528c73, 4'b1110));
    vecs.push_back(mk(0,  4,  89, 24'h102939, 4'b1110));
    vecs.push_back(mk(0,  4,  92, 24'hefffce, 4'b1110));
    vecs.push_back(mk(0,  4, 559, 24'h102939, 4'b1110));
    vecs.push_back(mk(0,  4, 560, 24'h000000, 4'b1110));
    vecs.push_back(mk(0,  6,  84, 24'hadd694, 4'b1110));
    vecs.push_back(mk(0,  7,  80, 24'hefffce, 4'b1110));
    vecs.push_back(mk(0, 15, 559, 24'h102939, 4'b1110));
    vecs.push_back(mk(0, 16, 100, 24'h000000, 4'b1110));
    vecs.push_back(mk(0, 19, 639, 24'h000000, 4'b1110));
    vecs.push_back(mk(0, 20,   0, 24'h000000, 4'b0110));
    vecs.push_back(mk(0, 21, 799, 24'h000000, 4'b0110));
    vecs.push_back(mk(0, 22,   0, 24'h000000, 4'b0100));
    vecs.push_back(mk(0, 23, 700, 24'h000000, 4'b0000));
    vecs.push_back(mk(0, 24,   0, 24'h000000, 4'b0110));
    vecs.push_back(mk(0, 26, 799, 24'h000000, 4'b0110));
    vecs.push_back(mk(1,  0,   0, 24'h000000, 4'b1111));

    repeat (3) @(posedge clock25);
    #1;
    chk_rgb("reset rgb", 24'h000000);
    chk_ctl("reset ctl", 4'b0110);
    chk("reset fb_addr", {17'h0, bus.fb_addr}, 32'h0);

    @(negedge clock25);
    resetn  = 1'b1;
    n_edges = 0;

    foreach (vecs[i]) begin
      goto_px(vecs[i].f, vecs[i].vc, vecs[i].hc);
      chk_rgb($sformatf("px f%0d v%0d h%0d rgb", vecs[i].f, vecs[i].vc, vecs[i].hc), vecs[i].rgb);
      chk_ctl($sformatf("px f%0d v%0d h%0d ctl", vecs[i].f, vecs[i].vc, vecs[i].hc), vecs[i].ctl);
    end

    // Border becomes pure red; window content unaffected.
    goto_px(1, 1, 0);
    bus.border_we    = 1'b1;
    bus.border_wdata = 15'h001f;
    tick();
    bus.border_we    = 1'b0;
    goto_px(1, 4,   0); chk_rgb("border h0",   24'hff0000);
    goto_px(1, 4,  79); chk_rgb("border h79",  24'hff0000);
    goto_px(1, 4,  80); chk_rgb("window h80",  24'hefffce);
    goto_px(1, 4, 560); chk_rgb("border h560", 24'hff0000);

    // Address sequence: lines 4..6 reread row 0, line 7 starts row 1.
    goto_addr(1,  5,  80); chk("addr v5 h80",   {17'h0, bus.fb_addr}, 32'd0);
    goto_addr(1,  5,  82); chk("addr v5 h82",   {17'h0, bus.fb_addr}, 32'd0);
    goto_addr(1,  5,  83); chk("addr v5 h83",   {17'h0, bus.fb_addr}, 32'd1);
    goto_addr(1,  5, 559); chk("addr v5 h559",  {17'h0, bus.fb_addr}, 32'd159);
    goto_addr(1,  6,  80); chk("addr v6 h80",   {17'h0, bus.fb_addr}, 32'd0);
    goto_addr(1,  7,  80); chk("addr v7 h80",   {17'h0, bus.fb_addr}, 32'd160);
    goto_addr(1,  7,  83); chk("addr v7 h83",   {17'h0, bus.fb_addr}, 32'd161);

    // Palette write to entry 5 landing on the same edge as a lookup of entry 5.
    goto_px(1, 8, 0);
    fs_mode = 1;
    goto_px(1, 10, 199); chk_rgb("pal before", 24'hadd694);
    bus.pal_we    = 1'b1;
    bus.pal_addr  = 4'd5;
    bus.pal_wdata = 15'h7c00;
    goto_px(1, 10, 200); chk_rgb("pal same cycle old", 24'hadd694);
    bus.pal_we    = 1'b0;
    goto_px(1, 10, 201); chk_rgb("pal next new", 24'h0000ff);
    goto_px(1, 10, 300); chk_rgb("pal later new", 24'h0000ff);

    // LCD off: window white, border still shown.
    goto_px(1, 11, 700);
    bus.lcd_on = 1'b0;
    goto_px(1, 12,  79); chk_rgb("lcd off border left",  24'hff0000);
    goto_px(1, 12,  80); chk_rgb("lcd off window first", 24'hffffff);
    goto_px(1, 12, 559); chk_rgb("lcd off window last",  24'hffffff);
    goto_px(1, 12, 560); chk_rgb("lcd off border right", 24'hff0000);
    goto_px(1, 12, 700);
    bus.lcd_on = 1'b1;
    goto_px(1, 13, 100); chk_rgb("lcd on again", 24'h0000ff);

    goto_addr(1, 15, 559); chk("addr last", {17'h0, bus.fb_addr}, 32'd639);

    // Reset inside hsync of a window line: immediate effect, then a fresh frame.
    goto_px(1, 15, 700);
    chk_ctl("pre-reset ctl", 4'b0010);
    #2;
    resetn = 1'b0;
    #1;
    chk_ctl("async reset ctl", 4'b0110);
    chk_rgb("async reset rgb", 24'h000000);
    chk("async reset fb_addr", {17'h0, bus.fb_addr}, 32'h0);
    repeat (3) @(posedge clock25);
    @(negedge clock25);
    resetn  = 1'b1;
    n_edges = 0;
    goto_px(0, 0,   0); chk_ctl("restart ctl", 4'b1111);
    goto_px(0, 4,  79); chk_rgb("restart border reset", 24'h000000);
    goto_px(0, 4, 100); chk_rgb("restart palette reset", 24'hadd694);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
